imm_gen_pipe: RTL

Parametrised, registered successor to the combinational immediate generator in the AdamRiscv decode path. It accepts one 32-bit instruction per beat over a valid/ready handshake and returns an XLEN-wide sign-extended immediate, a type code and an illegal-opcode flag. It also supports configurable custom matrix-instruction opcodes and a saturating branch-decode counter for debug; the counter replaces simulation-only printing. It sits between fetch/IF-ID and the ID/EX register, and a 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/imm_gen_pipe.sv | 95 +++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/matrix immediate decoder behind a 2-entry valid/ready skid buffer
module imm_gen_pipe #(
  parameter int         XLEN      = 32,
  parameter logic [6:0] MTYPE_OPC = 7'b0001011,
  parameter logic [2:0] M_LD_F3   = 3'b000,
  parameter logic [2:0] M_ST_F3   = 3'b001,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       imm_type_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] br_cnt_o,
  input  logic             br_cnt_clr
);
  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate
  localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_ML = 3'd6, T_MS = 3'd7;
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
  } res_t;
  logic [6:0]         opc;
  logic [2:0]         f3;
  logic signed [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, sel;
  res_t               d, e0, e1;
  logic [1:0]         cnt, wr;
  logic               push, pop;
  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign i_imm = {{20{inst_i[31]}}, inst_i[31:20]};
  assign s_imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign b_imm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign u_imm = {inst_i[31:12], 12'b0};
  assign j_imm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  always_comb begin
    d.typ = T_NONE;
    d.ill = 1'b0;
    if (opc == MTYPE_OPC) begin
      d.typ = f3 == M_LD_F3 ? T_ML : f3 == M_ST_F3 ? T_MS : T_NONE;
      d.ill = f3 != M_LD_F3 && f3 != M_ST_F3;
    end else begin
      case (opc)
        7'b0000011, 7'b0010011, 7'b1100111: d.typ = T_I;
        7'b0100011:                         d.typ = T_S;
        7'b1100011:                         d.typ = T_B;
        7'b0110111, 7'b0010111:             d.typ = T_U;
        7'b1101111:                         d.typ = T_J;
        7'b0110011, 7'b0001111, 7'b1110011: d.typ = T_NONE;
        default:                            d.ill = 1'b1;
      endcase
    end
    sel = (d.typ == T_I || d.typ == T_ML) ? i_imm :
          (d.typ == T_S || d.typ == T_MS) ? s_imm :
          d.typ == T_B ? b_imm :
          d.typ == T_U ? u_imm :
          d.typ == T_J ? j_imm : 32'sd0;
    d.imm = XLEN'(sel);
  end
  // full-ness is registered; out_ready is the only combinational term into in_ready
  assign out_valid = cnt != 2'd0;
  assign in_ready  = ~cnt[1] | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr        = cnt - {1'b0, pop};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= 2'd0;
      e0       <= '0;
      e1       <= '0;
      br_cnt_o <= '0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop) e0 <= e1;
      if (push && wr == 2'd0) e0 <= d;
      if (push && wr == 2'd1) e1 <= d;
      if (br_cnt_clr) br_cnt_o <= '0;
      else if (push && d.typ == T_B && !(&br_cnt_o)) br_cnt_o <= br_cnt_o + 1'b1;
    end
  end
  assign imm_o      = e0.imm;
  assign imm_type_o = e0.typ;
  assign illegal_o  = e0.ill;
endmodule
